// File: rtl/merge_2_pkg.sv
// merge_2 shared types: default widths, FSM state, source ID.
// Imported by merge_2 and rr_arb2.
package merge_2_pkg;

  localparam int DATA_W_DEF = 11;
  localparam int CTRL_W_DEF = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef enum logic {
    SRC_IN1 = 1'b0,
    SRC_IN2 = 1'b1
  } src_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter, pointer moves to loser.
// Ports: clk, reset (sync, high), req[1:0], en -> grant[1:0].
import merge_2_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // ptr=0: in1 has priority, ptr=1: in2 has priority
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): grant = ptr ? 2'b10 : 2'b01;
        (req == 2'b01): grant = 2'b01;
        (req == 2'b10): grant = 2'b10;
        default:        grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/merge_2.sv
// merge_2: merges two valid/ready inputs into one output plus
// a source-ID control channel (enabled by MERGE_2_CTRL_EN).
// Ports: clk, reset (sync, high), in1_*/in2_* inputs,
// out_* merged output, ctrl_* source-ID output channel.
import merge_2_pkg::*;

module merge_2 #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_valid,
  output logic              in2_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_data,
  output logic              ctrl_valid,
  input  logic              ctrl_ready
);

`ifdef MERGE_2_CTRL_EN
  localparam logic CTRL_ON = 1'b1;
`else
  localparam logic CTRL_ON = 1'b0;
`endif

  state_t            state;
  logic              dv;
  logic              cv;
  logic [DATA_W-1:0] dreg;
  src_t              src;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              en;
  logic              ohs;
  logic              chs;
  logic              dv_n;
  logic              cv_n;

  assign req = {in2_valid, in1_valid};
  assign en  = (state == IDLE) && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (en),
    .grant (grant)
  );

  assign in1_ready = grant[0];
  assign in2_ready = grant[1];

  assign ohs = dv & out_ready;
`ifdef MERGE_2_CTRL_EN
  assign chs = cv & ctrl_ready;
`else
  logic unused_ctrl;
  assign chs = 1'b0;
  assign unused_ctrl = ^{ctrl_ready, src};
`endif
  assign dv_n = dv & ~ohs;
  assign cv_n = cv & ~chs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dv    <= 1'b0;
      cv    <= 1'b0;
      dreg  <= '0;
      src   <= SRC_IN1;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            state <= HOLD;
            dv    <= 1'b1;
            cv    <= CTRL_ON;
            dreg  <= grant[1] ? in2_data : in1_data;
            src   <= grant[1] ? SRC_IN2 : SRC_IN1;
          end
        end
        HOLD: begin
          dv <= dv_n;
          cv <= cv_n;
          if (!dv_n && !cv_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // reset masks outputs at once so a held packet never completes
  assign out_valid = dv & ~reset;
  assign out_data  = reset ? '0 : dreg;
`ifdef MERGE_2_CTRL_EN
  assign ctrl_valid = cv & ~reset;
  assign ctrl_data  = reset ? '0 : CTRL_W'(src);
`else
  assign ctrl_valid = 1'b0;
  assign ctrl_data  = '0;
`endif

endmodule

// File: tb/tb_merge_2.sv
// tb_merge_2: scoreboard bench for merge_2.
// Model predicts grants; queue holds granted packets in order.
module tb_merge_2;

`ifdef MERGE_2_CTRL_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] in1_data, in2_data, out_data;
  logic        in1_valid, in1_ready;
  logic        in2_valid, in2_ready;
  logic        out_valid, out_ready;
  logic [0:0]  ctrl_data;
  logic        ctrl_valid, ctrl_ready;

  merge_2 dut (
    .clk        (clk),
    .reset      (reset),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in2_data   (in2_data),
    .in2_valid  (in2_valid),
    .in2_ready  (in2_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ctrl_data  (ctrl_data),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [11:0] q[$];
  bit midle = 1'b1;
  bit mptr  = 1'b0;
  bit mdp   = 1'b0;
  bit mcp   = 1'b0;
  int nout  = 0;
  int nctl  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // evaluate one cycle at negedge, then advance past posedge
  task automatic step();
    bit g1, g2, ev, ecv;
    @(negedge clk);
    g1 = 1'b0;
    g2 = 1'b0;
    if (midle && !reset) begin
      if (in1_valid && in2_valid) begin
        g1 = !mptr;
        g2 = mptr;
      end else begin
        g1 = in1_valid;
        g2 = in2_valid;
      end
    end
    ev  = mdp && !reset;
    ecv = mcp && !reset;
    chk("in1_ready", in1_ready, g1);
    chk("in2_ready", in2_ready, g2);
    chk("out_valid", out_valid, ev);
    chk("ctrl_valid", ctrl_valid, ecv);
    if (!CEN || reset) chk("ctrl_data0", ctrl_data, 0);
    if (ev || ecv) begin
      chk("sb_size", q.size() != 0, 1);
      if (q.size() != 0) begin
        if (ev) chk("out_data", out_data, q[0][10:0]);
        if (ecv) chk("ctrl_data", ctrl_data, q[0][11]);
      end
    end
    if (reset) begin
      midle = 1'b1;
      mptr  = 1'b0;
      mdp   = 1'b0;
      mcp   = 1'b0;
      q.delete();
    end else if (g1 || g2) begin
      q.push_back({g2, g2 ? in2_data : in1_data});
      mptr  = g1;
      midle = 1'b0;
      mdp   = 1'b1;
      mcp   = CEN;
    end else if (!midle) begin
      if (mdp && out_ready) begin
        mdp = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        nout++;
      end
      if (mcp && ctrl_ready) begin
        mcp = 1'b0;
        nctl++;
      end
      if (!mdp && !mcp) midle = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v1, logic [10:0] d1, bit v2,
                       logic [10:0] d2, bit ordy, bit crdy);
    in1_valid  = v1;
    in1_data   = d1;
    in2_valid  = v2;
    in2_data   = d2;
    out_ready  = ordy;
    ctrl_ready = crdy;
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 1, 1);
    repeat (2) step();
    chk("rst_odata", out_data, 0);
    chk("rst_cdata", ctrl_data, 0);
    reset = 1'b0;

    // single in1 packet
    drive(1, 11'h2A5, 0, 0, 1, 1);
    #1;
    chk("r32_rdy", in1_ready, 1);
    step();
    drive(0, 0, 0, 0, 1, 1);
    chk("r32_data", out_data, 11'h2A5);
    chk("r32_ctl", ctrl_data, 0);
    chk("r32_val", out_valid, 1);
    repeat (3) step();

    // both inputs busy: alternate, one packet per 2 cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1, 11'h001, 1, 11'h7FF, 1, 1);
    n0 = nout;
    repeat (12) step();
    chk("r33_thru", nout - n0, 6);
    drive(0, 0, 0, 0, 1, 1);
    repeat (3) step();

    // held in2 packet with out stalled
    drive(0, 0, 1, 11'h155, 0, 1);
    step();
    in2_valid = 1'b0;
    n0 = nctl;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r34_hold", out_data, 11'h155);
    end
    chk("r34_ctl", nctl - n0, CEN ? 1 : 0);
    out_ready = 1'b1;
    repeat (3) step();

    // reset while holding
    drive(1, 11'h3C3, 0, 0, 0, 0);
    step();
    in1_valid = 1'b0;
    step();
    reset = 1'b1;
    n0 = nout;
    step();
    reset = 1'b0;
    chk("r35_oval", out_valid, 0);
    chk("r35_cval", ctrl_valid, 0);
    drive(1, 11'h001, 1, 11'h7FF, 1, 1);
    #1;
    chk("r35_first", in1_ready, 1);
    step();
    drive(0, 0, 0, 0, 1, 1);
    repeat (3) step();
    chk("r35_nout", nout - n0, 1);

`ifndef MERGE_2_CTRL_EN
    // ctrl sink stalled forever: must not matter
    drive(1, 11'h0AA, 1, 11'h055, 1, 0);
    n0 = nout;
    repeat (12) step();
    chk("r36_thru", nout - n0, 6);
    drive(0, 0, 0, 0, 1, 0);
    repeat (3) step();
`endif

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 1), 11'($urandom),
            $urandom_range(0, 1), 11'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1));
      step();
    end
    drive(0, 0, 0, 0, 1, 1);
    repeat (4) step();
    chk("sb_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/merge_2.md
MERGE_2 -- requirements
Module: merge_2

Interface
REQ-001 Parameter: DATA_W, default 11, packet payload width in bits.
REQ-002 Parameter: CTRL_W, default 1, source-ID width; value 0 = inPort1, 1 = inPort2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-005 Port: in1_data  input  DATA_W  payload offered on inPort1.
REQ-006 Port: in1_valid  input  1  inPort1 packet present.
REQ-007 Port: in1_ready  output  1  inPort1 packet accepted this cycle.
REQ-008 Port: in2_data / in2_valid / in2_ready  input/input/output  DATA_W/1/1  as REQ-005..007 for inPort2.
REQ-009 Port: out_data  output  DATA_W  merged packet payload.
REQ-010 Port: out_valid  output  1  out_data held and pending.
REQ-011 Port: out_ready  input  1  downstream accepts out_data.
REQ-012 Port: ctrl_data  output  CTRL_W  source ID of the held packet; this channel drives a split_2-style control input.
REQ-013 Port: ctrl_valid / ctrl_ready  output/input  1/1  control-channel handshake.

Function
REQ-014 A transfer on any channel SHALL occur exactly on a rising edge where valid and ready are both 1.
REQ-015 States: IDLE (no packet held) and HOLD (packet held, data and/or control pending).
REQ-016 In IDLE, when one or both inputs are valid, the round-robin arbiter SHALL grant exactly one input; the granted inX_ready SHALL be 1 combinationally in the same cycle, and the other input's ready SHALL be 0.
REQ-017 When both inputs are valid, the input named by the priority pointer SHALL win.
REQ-018 After each grant, the pointer SHALL move to the non-granted input; with no grant, the pointer SHALL hold.
REQ-019 On the accepting edge, the block SHALL register payload and source ID, set data-pending and ctrl-pending, and enter HOLD; out_valid and ctrl_valid SHALL be 1 in the next cycle (latency 1 cycle).
REQ-020 In HOLD, both input readys SHALL be 0, and out_data and ctrl_data SHALL remain stable.
REQ-021 Each pending flag SHALL clear independently on its own channel's handshake; the corresponding valid SHALL drop in the following cycle.
REQ-022 When both flags are clear, the block SHALL return to IDLE; if both handshakes occur on the same edge, the block SHALL be in IDLE on the next cycle.
REQ-023 Peak throughput SHALL be one packet per 2 cycles; no packet SHALL be dropped, duplicated or reordered relative to its grant order.
REQ-024 in*_data SHALL pass bit-exact at DATA_W with no width conversion.

Reset
REQ-025 While reset=1: state=IDLE, out_valid=0, ctrl_valid=0, in1_ready=0, in2_ready=0, out_data=0, ctrl_data=0, pointer=inPort1.
REQ-026 Reset asserted while in HOLD SHALL discard the held packet with no completion on either output.
REQ-027 In the first cycle after reset deasserts, inputs SHALL be eligible for arbitration.

Configuration
REQ-028 Macro MERGE_2_CTRL_EN: when defined, the control channel SHALL operate per REQ-012/013/019/021.
REQ-029 When MERGE_2_CTRL_EN is undefined, ctrl_valid SHALL be tied to 0 and ctrl_data to 0, ctrl_ready SHALL be ignored, and HOLD SHALL exit on the out handshake alone.

Structure
REQ-030 Package merge_2_pkg SHALL hold the DATA_W and CTRL_W defaults, the state enum (IDLE, HOLD), and the source-ID typedef (SRC_IN1=0, SRC_IN2=1).
REQ-031 The block SHALL instantiate one sub-module, rr_arb2: a 2-way round-robin arbiter holding the pointer, with inputs req[1:0] and en, and outputs grant[1:0].

Verification
REQ-032 Only in1 valid with data 0x2A5, out_ready=ctrl_ready=1 -> in1_ready=1 in the same cycle; next cycle out_data=0x2A5, ctrl_data=0, both valids=1.
REQ-033 Both inputs valid continuously (in1=0x001, in2=0x7FF), sinks always ready -> outputs alternate 0x001/ctrl 0, 0x7FF/ctrl 1, 0x001...; one packet every 2 cycles.
REQ-034 Held packet 0x155 from in2, ctrl_ready=1 and out_ready=0 for 5 cycles -> ctrl handshake once, then ctrl_valid=0; out_data stays 0x155 for all 5 cycles; both input readys stay 0; IDLE after out_ready=1.
REQ-035 reset=1 in HOLD with 0x3C3 pending -> next cycle both valids=0, 0x3C3 never transfers; after reset, first grant with both inputs valid goes to in1.
REQ-036 Build without MERGE_2_CTRL_EN, ctrl_ready=0 throughout -> packets still flow at 1 per 2 cycles; ctrl_valid=0 always.
